hnf_txreq_arb: RTL

HNF_TXREQ_ARB -- requirements
Module: hnf_txreq_arb

---
 rtl/hnf_txreq_arb.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hnf_txreq_arb.sv
// hnf_txreq_arb: CHI home-node TXREQ channel arbiter.
// Round-robin selection among NUM_REQ request sources, L-credit accounting,
// and the STOP/RUN/DRAIN link state machine with credit return on drain.
// Optional feature: define HNF_TXREQ_QOS_EN so that the highest req_flit.qos
// among valid sources wins and round-robin only breaks ties.

package hnf_txreq_pkg;

  typedef struct packed {
    logic [3:0]  qos;
    logic [10:0] tgt_id;
    logic [10:0] src_id;
    logic [11:0] txn_id;
    logic [6:0]  opcode;
    logic [47:0] addr;
  } reqflit_t;

  localparam logic [6:0] OPC_REQLCRDRETURN = 7'h00;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } link_state_e;

endpackage

module hnf_txreq_arb
  import hnf_txreq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_CRD = 15
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  reqflit_t [NUM_REQ-1:0] req_flit,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   link_active,
  output reqflit_t               txreqflit,
  output logic                   txreqflitv,
  output logic                   txreqflitpend,
  input  logic                   txreqlcrdv,
  output logic [3:0]             crd_cnt,
  output logic                   link_stopped,
  output logic                   crd_err
);

  localparam int             PTR_W       = $clog2(NUM_REQ);
  localparam logic [PTR_W:0] NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
  localparam logic [3:0]     MAX_CNT     = 4'(MAX_CRD);

  link_state_e        state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]         crd_cnt_q, crd_cnt_d;
  logic               crd_err_q, crd_err_d;
  reqflit_t           flit_q, flit_d;
  logic               flitv_q, flitv_d;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand_sum;
`ifdef HNF_TXREQ_QOS_EN
  logic [3:0]         max_qos;
`endif

  logic               grant;
  logic               link_send;
  logic               send;
  reqflit_t           send_flit;

  // Pick the first eligible source at or after rr_ptr, wrapping around.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    eligible = req_valid;
`ifdef HNF_TXREQ_QOS_EN
    max_qos = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (req_flit[i].qos > max_qos)) max_qos = req_flit[i].qos;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (req_flit[i].qos == max_qos);
    end
`endif
    found    = 1'b0;
    win_idx  = '0;
    cand_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (cand_sum >= NUM_REQ_EXT) cand_sum = cand_sum - NUM_REQ_EXT;
      if (!found && eligible[cand_sum[PTR_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand_sum[PTR_W-1:0];
      end
    end
  end

  // Decide this cycle's send, then the next state, credits and output flit.
  always_comb begin
    // Sends use the registered credit count, so a credit arriving at zero
    // only enables a send from the following cycle. Gating with rst_n keeps
    // ready/pend low while reset is held.
    grant     = rst_n && (state_q == ST_RUN) && (crd_cnt_q != 4'd0) && found;
    link_send = rst_n && (state_q == ST_DRAIN) && (crd_cnt_q != 4'd0);
    send      = grant || link_send;

    req_ready = '0;
    if (grant) req_ready[win_idx] = 1'b1;

    send_flit = '0;
    if (grant) send_flit = req_flit[win_idx];
    else       send_flit.opcode = OPC_REQLCRDRETURN;

    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // A credit and a send in the same cycle cancel out; an extra credit at
    // the ceiling is dropped and flagged.
    crd_cnt_d = crd_cnt_q;
    crd_err_d = crd_err_q;
    if (txreqlcrdv && !send) begin
      if (crd_cnt_q == MAX_CNT) crd_err_d = 1'b1;
      else                      crd_cnt_d = crd_cnt_q + 4'd1;
    end else if (!txreqlcrdv && send) begin
      crd_cnt_d = crd_cnt_q - 4'd1;
    end

    flitv_d = send;
    flit_d  = send ? send_flit : flit_q;

    state_d = state_q;
    unique case (state_q)
      ST_STOP:  if (link_active) state_d = ST_RUN;
      ST_RUN:   if (!link_active) state_d = ST_DRAIN;
      // With zero credits nothing is loaded this cycle, so the last link
      // flit leaves the output register at this edge and the link can stop.
      ST_DRAIN: if (crd_cnt_q == 4'd0) state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  // State, credit and output-register update with synchronous reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      // NOTE: the flit payload is a plain register bank rather than a
      // memory, so it is reset too and reads zero after reset.
      state_q   <= ST_STOP;
      rr_ptr_q  <= '0;
      crd_cnt_q <= 4'd0;
      crd_err_q <= 1'b0;
      flit_q    <= '0;
      flitv_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      crd_cnt_q <= crd_cnt_d;
      crd_err_q <= crd_err_d;
      flit_q    <= flit_d;
      flitv_q   <= flitv_d;
    end
  end

  assign txreqflit     = flit_q;
  assign txreqflitv    = flitv_q;
  assign txreqflitpend = send;
  assign crd_cnt       = crd_cnt_q;
  assign crd_err       = crd_err_q;
  assign link_stopped  = (state_q == ST_STOP) || !rst_n;

endmodule
